// File: rtl/pll_lock_seq.sv
// pll_lock_seq: PLL reset sequencer and lock qualifier with a registered system reset release.
// Define PLL_LOCK_TIMEOUT_EN to add a WAIT_LOCK timeout with a sticky timeout_err flag.
module pll_lock_seq #(
  parameter int SYNC_STAGES        = 2,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 65536,
  parameter int CNT_W              = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             sw_relock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             ready,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] loss_count,
  output logic             timeout_err
);
  localparam int HW = RST_HOLD_CYCLES > 1 ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int LW = LOCK_STABLE_CYCLES > 1 ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [LW-1:0] STAB_LAST = LW'(LOCK_STABLE_CYCLES - 1);
  typedef enum logic [1:0] {PLL_RST = 2'd0, WAIT_LOCK = 2'd1, RUN = 2'd2} state_t;
  state_t             state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [HW-1:0]      hold_q, hold_d;
  logic [LW-1:0]      stab_q, stab_d;
  logic [CNT_W-1:0]   loss_q, loss_d;
  logic               pll_rst_q, pll_rst_d, sys_rst_n_q, sys_rst_n_d, ready_q, ready_d;
  logic               locked_s, loss_evt;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit, terr_q;
`endif
  assign locked_s = sync_q[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q      <= '0;
      state_q     <= PLL_RST;
      hold_q      <= '0;
      stab_q      <= '0;
      loss_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_locked};
      state_q     <= state_d;
      hold_q      <= hold_d;
      stab_q      <= stab_d;
      loss_q      <= loss_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
    end
  end
  // Counters default to zero so every state entry and every relock starts them clean.
  always_comb begin
    state_d  = state_q;
    hold_d   = '0;
    stab_d   = '0;
    loss_evt = state_q == RUN && !locked_s;
`ifdef PLL_LOCK_TIMEOUT_EN
    tmo_d   = '0;
    tmo_hit = 1'b0;
`endif
    if (loss_evt || sw_relock) begin
      state_d = PLL_RST;
    end else if (state_q == PLL_RST) begin
      hold_d  = hold_q == HOLD_LAST ? '0 : hold_q + 1'b1;
      state_d = hold_q == HOLD_LAST ? WAIT_LOCK : PLL_RST;
    end else if (state_q == WAIT_LOCK) begin
      stab_d  = (locked_s && stab_q != STAB_LAST) ? stab_q + 1'b1 : '0;
      state_d = (locked_s && stab_q == STAB_LAST) ? RUN : WAIT_LOCK;
`ifdef PLL_LOCK_TIMEOUT_EN
      tmo_hit = tmo_q == TMO_LAST;
      tmo_d   = tmo_hit ? '0 : tmo_q + 1'b1;
      if (tmo_hit) state_d = PLL_RST;
`endif
    end
  end
  always_comb begin
    pll_rst_d   = state_d == PLL_RST;
    sys_rst_n_d = state_d == RUN;
    ready_d     = state_d == RUN;
    loss_d      = (loss_evt && loss_q != '1) ? loss_q + 1'b1 : loss_q;
  end
`ifdef PLL_LOCK_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tmo_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      terr_q <= terr_q | tmo_hit;
    end
  end
  assign timeout_err = terr_q;
`else
  assign timeout_err = TIMEOUT_CYCLES < 0;
`endif
  assign pll_rst    = pll_rst_q;
  assign sys_rst_n  = sys_rst_n_q;
  assign ready      = ready_q;
  assign state_o    = state_q;
  assign loss_count = loss_q;
endmodule

// File: tb/tb_pll_lock_seq.sv
// tb_pll_lock_seq: directed scenarios with a per-cycle behavioural model and literal checkpoints.
module tb_pll_lock_seq;
  localparam int SYNC = 2, HOLD = 4, STABLE = 8, TMO = 64, CW = 2;
  localparam int LOSS_MAX = (1 << CW) - 1;
`ifdef PLL_LOCK_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, pll_locked = 1'b0, sw_relock = 1'b0;
  logic pll_rst, sys_rst_n, ready, timeout_err;
  logic [1:0] state_o;
  logic [CW-1:0] loss_count;
  int checks = 0, failures = 0;

  pll_lock_seq #(.SYNC_STAGES(SYNC), .RST_HOLD_CYCLES(HOLD), .LOCK_STABLE_CYCLES(STABLE),
                 .TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sw_relock(sw_relock),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .ready(ready), .state_o(state_o),
    .loss_count(loss_count), .timeout_err(timeout_err));

  always #5 clk = ~clk;

  // Model: lock seen SYNC edges late, time spent in the current state, length of the current lock run.
  bit hist [SYNC];
  int m_st = 0, m_in = 0, m_run = 0, m_loss = 0;
  bit m_terr = 0, m_valid = 0;
  always @(posedge clk) begin
    bit ls;
    int nx;
    if (!rst_n) begin
      m_st = 0; m_in = 0; m_run = 0; m_loss = 0; m_terr = 0; m_valid = 1;
      for (int k = 0; k < SYNC; k++) hist[k] = 0;
    end else begin
      ls = hist[SYNC-1];
      for (int k = SYNC - 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = pll_locked;
      if (m_st == 1) m_run = ls ? m_run + 1 : 0;
      nx = m_st;
      if (m_st == 2 && !ls) begin
        nx = 0;
        if (m_loss < LOSS_MAX) m_loss++;
      end else if (sw_relock) nx = 0;
      else if (m_st == 0 && m_in + 1 == HOLD) nx = 1;
      else if (m_st == 1 && TMO_EN && m_in + 1 == TMO) begin
        nx = 0;
        m_terr = 1;
      end else if (m_st == 1 && m_run == STABLE) nx = 2;
      m_in = (nx != m_st || sw_relock) ? 0 : m_in + 1;
      if (nx != 1 || sw_relock) m_run = 0;
      m_st = nx;
    end
  end

  always @(negedge clk) begin
    logic [7:0] exp_v, act_v;
    if (m_valid) begin
      exp_v = {m_st[1:0], m_st == 0, m_st == 2, m_st == 2, m_loss[CW-1:0], m_terr};
      act_v = {state_o, pll_rst, sys_rst_n, ready, loss_count, timeout_err};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL model t=%0t {state,pll_rst,sys_rst_n,ready,loss,terr} got=%b want=%b", $time, act_v, exp_v);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string name);
    chk({name, "_state"}, 32'(state_o), 0);
    chk({name, "_pll_rst"}, 32'(pll_rst), 1);
    chk({name, "_sys_rst_n"}, 32'(sys_rst_n), 0);
    chk({name, "_ready"}, 32'(ready), 0);
    chk({name, "_loss"}, 32'(loss_count), 0);
    chk({name, "_terr"}, 32'(timeout_err), 0);
  endtask

  int loss_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    // 1: reset then clean lock
    tick(3);
    chk_reset("rst");
    rst_n = 1'b1;
    tick(3);
    chk("hold_edge3", 32'(pll_rst), 1);
    tick(1);
    chk("hold_edge4", 32'(pll_rst), 0);
    chk("wait_state", 32'(state_o), 1);
    tick(5);
    pll_locked = 1'b1;
    tick(9);
    chk("lock_edge9_ready", 32'(ready), 0);
    tick(1);
    chk("lock_edge10_ready", 32'(ready), 1);
    chk("lock_edge10_sys", 32'(sys_rst_n), 1);
    chk("lock_state", 32'(state_o), 2);
    // 4a + 2: relock from RUN, then glitched lock in WAIT_LOCK
    sw_relock = 1'b1;
    pll_locked = 1'b0;
    tick(1);
    sw_relock = 1'b0;
    chk("relock_state", 32'(state_o), 0);
    chk("relock_loss", 32'(loss_count), 0);
    tick(4);
    chk("relock_wait", 32'(state_o), 1);
    pll_locked = 1'b1;
    tick(5);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(9);
    chk("glitch_ready15", 32'(ready), 0);
    tick(1);
    chk("glitch_ready16", 32'(ready), 1);
    // 3: repeated loss with saturation
    for (int i = 0; i < 5; i++) begin
      pll_locked = 1'b0;
      tick(2);
      chk("loss_edge2_ready", 32'(ready), 1);
      tick(1);
      chk("loss_edge3_sys", 32'(sys_rst_n), 0);
      chk("loss_edge3_pll_rst", 32'(pll_rst), 1);
      chk("loss_count", 32'(loss_count), 32'(loss_exp[i]));
      pll_locked = 1'b1;
      tick(12);
      chk("loss_relock_ready", 32'(ready), 1);
    end
    // 6: reset in RUN and in WAIT_LOCK
    rst_n = 1'b0;
    tick(1);
    chk_reset("rst_run");
    rst_n = 1'b1;
    tick(5);
    chk("rst_wait_state", 32'(state_o), 1);
    rst_n = 1'b0;
    tick(1);
    chk_reset("rst_wait");
    rst_n = 1'b1;
    tick(12);
    chk("rst_relock_ready", 32'(ready), 1);
    // 4b: relock in RUN, restart in PLL_RST, simultaneous relock and loss
    sw_relock = 1'b1;
    tick(1);
    sw_relock = 1'b0;
    chk("sw_state", 32'(state_o), 0);
    chk("sw_loss", 32'(loss_count), 0);
    tick(2);
    sw_relock = 1'b1;
    tick(1);
    sw_relock = 1'b0;
    tick(3);
    chk("restart_hold3", 32'(pll_rst), 1);
    tick(1);
    chk("restart_hold4", 32'(pll_rst), 0);
    tick(7);
    chk("restart_ready7", 32'(ready), 0);
    tick(1);
    chk("restart_ready8", 32'(ready), 1);
    pll_locked = 1'b0;
    tick(2);
    sw_relock = 1'b1;
    tick(1);
    sw_relock = 1'b0;
    chk("both_state", 32'(state_o), 0);
    chk("both_loss", 32'(loss_count), 1);
    // 5: timeout behaviour
    tick(4);
    chk("tmo_wait", 32'(state_o), 1);
    if (TMO_EN) begin
      tick(63);
      chk("tmo_edge63_state", 32'(state_o), 1);
      tick(1);
      chk("tmo_edge64_state", 32'(state_o), 0);
      chk("tmo_edge64_terr", 32'(timeout_err), 1);
      tick(4);
      chk("tmo_rewait", 32'(state_o), 1);
    end else begin
      tick(200);
      chk("notmo_state", 32'(state_o), 1);
      chk("notmo_terr", 32'(timeout_err), 0);
    end
    pll_locked = 1'b1;
    tick(10);
    chk("tmo_lock_ready", 32'(ready), 1);
    chk("tmo_lock_terr", 32'(timeout_err), 32'(TMO_EN));
    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
